// File: rtl/merge_sort_pkg.sv
// Shared types for the bottom-up merge sort scheduler: FSM states and the merge job payload.
package merge_sort_pkg;

   // Widest element index a job can carry; each instance uses only its low ADDR_W bits.
   localparam int JOB_ADDR_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      ADVANCE = 3'd3,
      FINISH  = 3'd4
   } sched_state_t;

   typedef struct packed {
      logic [JOB_ADDR_W-1:0] l_base;
      logic [JOB_ADDR_W-1:0] r_base;
      logic [JOB_ADDR_W:0]   len;
      logic                  bank;
   } merge_job_t;

endpackage

// File: rtl/merge_job_gen.sv
// Walks the bottom-up merge order: holds the next job to issue (base, run length, bank, pass)
// and steps it on advance; init rewinds to the first job of pass 0.
module merge_job_gen
   import merge_sort_pkg::*;
#(
   parameter  int N_ELEM = 16,
   localparam int ADDR_W = $clog2(N_ELEM),
   localparam int PASS_W = $clog2(ADDR_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init,
   input  logic              advance,
   output merge_job_t        job,
   output logic              last_job,
   output logic              last_pass,
   output logic [PASS_W-1:0] pass_idx
);

   localparam logic [ADDR_W:0] N_W = (ADDR_W + 1)'(N_ELEM);

   logic [ADDR_W:0]   base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              bank_q, bank_d;
   logic [PASS_W-1:0] pass_q, pass_d;
   logic [ADDR_W:0]   two_len_s;
   logic [ADDR_W:0]   next_base_s;
   logic [ADDR_W-1:0] r_base_s;

   // One bit of headroom keeps base + 2*len from wrapping at the end of a pass.
   always_comb begin
      two_len_s   = {len_q[ADDR_W-1:0], 1'b0};
      next_base_s = base_q + two_len_s;
      r_base_s    = base_q[ADDR_W-1:0] + len_q[ADDR_W-1:0];
      last_pass   = (two_len_s == N_W);
      last_job    = last_pass && (next_base_s >= N_W);
   end

   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      bank_d = bank_q;
      pass_d = pass_q;
      if (init) begin
         base_d = '0;
         len_d  = (ADDR_W + 1)'(1'b1);
         bank_d = 1'b0;
         pass_d = '0;
      end else if (advance) begin
         if (next_base_s < N_W) begin
            base_d = next_base_s;
         end else if (!last_pass) begin
            len_d  = two_len_s;
            base_d = '0;
            bank_d = ~bank_q;
            pass_d = pass_q + PASS_W'(1'b1);
         end else begin
            base_d = base_q;
         end
      end else begin
         base_d = base_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         len_q  <= (ADDR_W + 1)'(1'b1);
         bank_q <= 1'b0;
         pass_q <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         bank_q <= bank_d;
         pass_q <= pass_d;
      end
   end

   always_comb begin
      job.l_base = JOB_ADDR_W'(base_q[ADDR_W-1:0]);
      job.r_base = JOB_ADDR_W'(r_base_s);
      job.len    = (JOB_ADDR_W + 1)'(len_q);
      job.bank   = bank_q;
      pass_idx   = pass_q;
   end

endmodule

// File: rtl/merge_pass_scheduler.sv
// Sequences a full bottom-up merge sort through one shared merge engine.
// Optional SCHED_ERR_EN adds a sticky sched_err flag for protocol violations.
module merge_pass_scheduler
   import merge_sort_pkg::*;
#(
   parameter  int N_ELEM = 16,
   localparam int ADDR_W = $clog2(N_ELEM),
   localparam int PASS_W = $clog2(ADDR_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sort_start,
   output logic              sort_busy,
   output logic              sort_done,
   output logic              result_bank,
   output logic              job_valid,
   input  logic              job_ready,
   output logic [ADDR_W-1:0] job_l_base,
   output logic [ADDR_W-1:0] job_r_base,
   output logic [ADDR_W:0]   job_len,
   output logic              job_bank,
   input  logic              merge_done,
   output logic [PASS_W-1:0] pass_idx
`ifdef SCHED_ERR_EN
   ,
   output logic              sched_err
`endif
);

   sched_state_t state_q, state_d;
   merge_job_t   job_q, job_d;
   logic         job_valid_q, job_valid_d;
   logic         sort_busy_q, sort_busy_d;
   logic         sort_done_q, sort_done_d;
   logic         result_bank_q, result_bank_d;
   logic         last_q, last_d;
   logic         gen_init_s;
   logic         gen_adv_s;
   merge_job_t   gen_job_s;
   logic         gen_last_job_s;
   logic         gen_last_pass_s;
   logic         unused_bits_s;

   merge_job_gen #(
      .N_ELEM (N_ELEM)
   ) u_job_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .init      (gen_init_s),
      .advance   (gen_adv_s),
      .job       (gen_job_s),
      .last_job  (gen_last_job_s),
      .last_pass (gen_last_pass_s),
      .pass_idx  (pass_idx)
   );

   // The generator steps on merge_done so ADVANCE already sees the next job; last_q remembers
   // whether the job that just completed was the final one.
   always_comb begin
      state_d       = state_q;
      job_d         = job_q;
      last_d        = last_q;
      result_bank_d = result_bank_q;
      gen_init_s    = 1'b0;
      gen_adv_s     = 1'b0;
      case (state_q)
         IDLE: begin
            gen_init_s = 1'b1;
            if (sort_start) begin
               state_d = ISSUE;
               job_d   = gen_job_s;
               last_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (job_valid_q && job_ready) begin
               state_d = WAIT;
            end else begin
               state_d = ISSUE;
            end
         end
         WAIT: begin
            if (merge_done) begin
               state_d   = ADVANCE;
               gen_adv_s = 1'b1;
               last_d    = gen_last_job_s;
            end else begin
               state_d = WAIT;
            end
         end
         ADVANCE: begin
            if (last_q) begin
               state_d       = FINISH;
               result_bank_d = ~gen_job_s.bank;
            end else begin
               state_d = ISSUE;
               job_d   = gen_job_s;
            end
         end
         FINISH: begin
            // Rewind here too so a start accepted in the very next IDLE cycle sees pass 0.
            gen_init_s = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      job_valid_d = (state_d == ISSUE);
      sort_busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == ADVANCE);
      sort_done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         job_q         <= '0;
         job_valid_q   <= 1'b0;
         sort_busy_q   <= 1'b0;
         sort_done_q   <= 1'b0;
         result_bank_q <= 1'b0;
         last_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         job_q         <= job_d;
         job_valid_q   <= job_valid_d;
         sort_busy_q   <= sort_busy_d;
         sort_done_q   <= sort_done_d;
         result_bank_q <= result_bank_d;
         last_q        <= last_d;
      end
   end

`ifdef SCHED_ERR_EN
   logic sched_err_q, sched_err_d;

   always_comb begin
      sched_err_d = sched_err_q;
      if ((state_q == IDLE) && sort_start) begin
         sched_err_d = 1'b0;
      end else begin
         sched_err_d = sched_err_q;
      end
      if ((merge_done && (state_q != WAIT)) || (sort_start && sort_busy_q)) begin
         sched_err_d = 1'b1;
      end else begin
         sched_err_d = sched_err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sched_err_q <= 1'b0;
      end else begin
         sched_err_q <= sched_err_d;
      end
   end

   assign sched_err = sched_err_q;
`endif

   assign sort_busy     = sort_busy_q;
   assign sort_done     = sort_done_q;
   assign result_bank   = result_bank_q;
   assign job_valid     = job_valid_q;
   assign job_l_base    = job_q.l_base[ADDR_W-1:0];
   assign job_r_base    = job_q.r_base[ADDR_W-1:0];
   assign job_len       = job_q.len[ADDR_W:0];
   assign job_bank      = job_q.bank;
   assign unused_bits_s = ^{job_q, gen_last_pass_s};

endmodule
